// File: rtl/wb_merge_unit.sv
// wb_merge_unit: merges variable-latency result sources onto scoreboard write ports
// Ports: clk_i/rst_ni (async active-low), flush_i; src_*_i per-source valid/id/result/exception
// (sources cannot stall); wb_*_o per write port; busy_o (any FIFO occupied); overflow_o (sticky drop).
// Optional: WB_MERGE_PERF_EN adds stall_cnt_o, a saturating count of cycles with an ungranted ready source.
module wb_merge_unit #(
  parameter int NR_SRC        = 4,
  parameter int NR_WB_PORTS   = 2,
  parameter int FIFO_DEPTH    = 2,
  parameter int TRANS_ID_BITS = 3,
  parameter int EXC_W         = 129
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  input  logic [NR_SRC-1:0]                       src_valid_i,
  input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]    src_trans_id_i,
  input  logic [NR_SRC-1:0][63:0]                 src_result_i,
  input  logic [NR_SRC-1:0][EXC_W-1:0]            src_exception_i,
  output logic [NR_WB_PORTS-1:0]                  wb_valid_o,
  output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [NR_WB_PORTS-1:0][63:0]            wb_result_o,
  output logic [NR_WB_PORTS-1:0][EXC_W-1:0]       wb_exception_o,
  output logic                                    busy_o,
  output logic                                    overflow_o
`ifdef WB_MERGE_PERF_EN
  ,
  output logic [31:0]                             stall_cnt_o
`endif
);
  localparam int EW = TRANS_ID_BITS + 64 + EXC_W;
  localparam int PW = NR_SRC > 1 ? $clog2(NR_SRC) : 1;
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [EW-1:0] mem_q [NR_SRC][FIFO_DEPTH];
  logic [AW-1:0] rd_q [NR_SRC];
  logic [AW-1:0] wr_q [NR_SRC];
  logic [CW-1:0] cnt_q [NR_SRC];
  logic [NR_SRC-1:0] avail, gnt, push, pop, drop;
  logic [NR_SRC-1:0][EW-1:0] head;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [NR_WB_PORTS-1:0][PW-1:0] sel;
  logic [NR_WB_PORTS-1:0] pv, vld_q;
  logic [NR_WB_PORTS-1:0][EW-1:0] out_q;
  logic ov_q;
  for (genvar s = 0; s < NR_SRC; s++) begin : g_src
    logic [EW-1:0] in;
    logic full;
    assign in = {src_trans_id_i[s], src_result_i[s], src_exception_i[s]};
    assign full = cnt_q[s] == CW'(FIFO_DEPTH);
    // the incoming entry counts as a head when the FIFO is empty, giving 1-cycle latency
    assign avail[s] = !flush_i && (cnt_q[s] != '0 || src_valid_i[s]);
    assign head[s] = cnt_q[s] != '0 ? mem_q[s][rd_q[s]] : in;
    assign pop[s] = gnt[s] && cnt_q[s] != '0;
    // a granted entry bypassing an empty FIFO is never stored
    assign push[s] = !flush_i && src_valid_i[s] && !(gnt[s] && cnt_q[s] == '0) && (!full || gnt[s]);
    assign drop[s] = !flush_i && src_valid_i[s] && full && !gnt[s];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q[s] <= '0;
        rd_q[s]  <= '0;
        wr_q[s]  <= '0;
      end else if (flush_i) begin
        cnt_q[s] <= '0;
        rd_q[s]  <= '0;
        wr_q[s]  <= '0;
      end else begin
        cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
        if (pop[s]) rd_q[s] <= rd_q[s] == AW'(FIFO_DEPTH - 1) ? '0 : rd_q[s] + 1'b1;
        if (push[s]) wr_q[s] <= wr_q[s] == AW'(FIFO_DEPTH - 1) ? '0 : wr_q[s] + 1'b1;
      end
    end
    always_ff @(posedge clk_i) begin
      if (push[s]) mem_q[s][wr_q[s]] <= in;
    end
  end
  always_comb begin
    int n;
    gnt   = '0;
    pv    = '0;
    sel   = '0;
    ptr_d = ptr_q;
    n     = 0;
    for (int k = 0; k < NR_SRC; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NR_SRC;
      if (avail[idx] && n < NR_WB_PORTS) begin
        gnt[idx] = 1'b1;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
          if (p == n) begin
            pv[p]  = 1'b1;
            sel[p] = PW'(idx);
          end
        end
        n++;
        ptr_d = PW'((idx + 1) % NR_SRC);
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      out_q <= '0;
      ptr_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      vld_q <= pv;
      ptr_q <= flush_i ? '0 : ptr_d;
      ov_q  <= !flush_i && (ov_q || |drop);
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (pv[p]) out_q[p] <= head[sel[p]];
      end
    end
  end
  for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_port
    assign wb_trans_id_o[p]  = out_q[p][EW-1 -: TRANS_ID_BITS];
    assign wb_result_o[p]    = out_q[p][EXC_W +: 64];
    assign wb_exception_o[p] = out_q[p][EXC_W-1:0];
  end
  assign wb_valid_o = vld_q;
  assign overflow_o = ov_q;
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < NR_SRC; i++) busy_o = busy_o | (cnt_q[i] != '0);
  end
`ifdef WB_MERGE_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else if (flush_i) stall_q <= '0;
    else if (|(avail & ~gnt) && stall_q != '1) stall_q <= stall_q + 1'b1;
  end
  assign stall_cnt_o = stall_q;
`endif
endmodule
